// File: rtl/led_mode_sequencer_pkg.sv
// Shared mode encodings, FSM state type and small helpers for the LED mode sequencer.
package led_mode_sequencer_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_SOLID = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_CHASE = 2'b11;

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_SOLID     = 3'd1,
        S_BLINK_ON  = 3'd2,
        S_BLINK_OFF = 3'd3,
        S_CHASE     = 3'd4
    } led_state_t;

    // Entry state for a freshly decoded mode.
    function automatic led_state_t entry_state(input logic [1:0] mode_val);
        led_state_t st;
        case (mode_val)
            MODE_SOLID: st = S_SOLID;
            MODE_BLINK: st = S_BLINK_ON;
            MODE_CHASE: st = S_CHASE;
            default:    st = S_OFF;
        endcase
        return st;
    endfunction

    // Counter width for a count of n states; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_mode_sequencer_sw_debounce.sv
// Two-flop synchroniser followed by a stable-run debounce counter for one switch bit.
module sw_debounce
    import led_mode_sequencer_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    localparam int unsigned   CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          deb_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            deb_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= d_async;
            sync2_reg <= sync1_reg;
            // Any sample agreeing with the accepted value restarts the stability run.
            if (sync2_reg == deb_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                deb_reg <= sync2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign q = deb_reg;

endmodule

// File: rtl/led_mode_sequencer.sv
// LED bank controller: debounced switch mode decode, step prescaler and pattern FSM.
module led_mode_sequencer
    import led_mode_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 125000000,
    parameter int unsigned DEB_CYCLES = 1250000,
    parameter int unsigned NUM_LD     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        sw,
    output logic [NUM_LD-1:0] ld,
    output logic [1:0]        mode,
    output logic              tick
);

    localparam int unsigned       TW        = cnt_width(TICK_DIV);
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [NUM_LD-1:0] LD_FIRST  = {{(NUM_LD-1){1'b0}}, 1'b1};

    logic [1:0]        deb_sw;
    logic [1:0]        req_reg;
    logic [1:0]        mode_reg, mode_next;
    led_state_t        state_reg, state_next;
    logic [NUM_LD-1:0] ld_reg, ld_next;
    logic              tick_reg, tick_next;
    logic [TW-1:0]     cnt_reg, cnt_next;
    logic              mode_change;
    logic              step;

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .d_async(sw[gi]),
            .q      (deb_sw[gi])
        );
    end

    // Requested mode is registered once so the FSM compares two stable flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_reg   <= MODE_OFF;
            mode_reg  <= MODE_OFF;
            state_reg <= S_OFF;
            ld_reg    <= '0;
            tick_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            req_reg   <= deb_sw;
            mode_reg  <= mode_next;
            state_reg <= state_next;
            ld_reg    <= ld_next;
            tick_reg  <= tick_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        mode_change = (req_reg != mode_reg);
        step        = (cnt_reg == TICK_LAST);
        mode_next   = mode_reg;
        state_next  = state_reg;
        ld_next     = ld_reg;
        tick_next   = 1'b0;
        cnt_next    = step ? '0 : cnt_reg + TW'(1);

        // A mode change restarts the step period and swallows a coincident tick.
        if (mode_change) begin
            mode_next  = req_reg;
            state_next = entry_state(req_reg);
            cnt_next   = '0;
            case (req_reg)
                MODE_SOLID,
                MODE_BLINK: ld_next = '1;
                MODE_CHASE: ld_next = LD_FIRST;
                default:    ld_next = '0;
            endcase
        end else if (step) begin
            tick_next = 1'b1;
            case (state_reg)
                S_BLINK_ON: begin
                    state_next = S_BLINK_OFF;
                    ld_next    = '0;
                end
                S_BLINK_OFF: begin
                    state_next = S_BLINK_ON;
                    ld_next    = '1;
                end
                S_CHASE: ld_next = {ld_reg[NUM_LD-2:0], ld_reg[NUM_LD-1]};
                default: ;
            endcase
        end
    end

    assign ld   = ld_reg;
    assign mode = mode_reg;
    assign tick = tick_reg;

endmodule
